fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch buffer between the PC/instruction-memory stage and decode.
- Captures each (pc, instruction) pair fetched at the word-addressed PC; the PC advances by 1 per instruction.
- Holds pairs in a DEPTH-entry FIFO and presents them in order to decode with a valid/ready handshake.
- Drives a hold signal back to the PC register when full, and discards all buffered work on a taken-branch redirect (pcSrc).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  redirect (pcSrc asserted); empties the queue.
- fetch_valid  input  1  fetch stage offers a pair this cycle.
- fetch_pc  input  32  word address of the offered instruction.
- fetch_instr  input  32  instruction word read at fetch_pc.
- fetch_ready  output  1  queue can accept a pair this cycle.
- pc_hold  output  1  PC must not advance this cycle (= ~fetch_ready).
- dec_valid  output  1  head entry is valid.
- dec_pc  output  32  pc of the head entry.
- dec_instr  output  32  instruction of the head entry.
- dec_ready  input  1  decode consumes the head this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. Reset clears wr_ptr, rd_ptr, count and all storage to 0.
  - After reset: dec_valid=0, dec_pc=0, dec_instr=0, fetch_ready=1, pc_hold=0, count=0.
- Handshakes:
  - push = fetch_valid & fetch_ready.
  - pop = dec_valid & dec_ready.
- Full/empty:
  - fetch_ready = (count != DEPTH), depending on count only (no combinational path from dec_ready).
  - When full, a same-cycle pop does not allow a push.
  - dec_valid = (count != 0).
- Outputs: dec_pc and dec_instr are read from storage[rd_ptr].
  - When empty they show the stale entry; decode must ignore them.
- Latency: an entry pushed at edge N is visible on dec_* from edge N (the cycle after it is offered). The minimum fetch-to-decode latency is 1 cycle.
- Push: writes {fetch_pc, fetch_instr} to storage[wr_ptr] and increments wr_ptr.
- Pop: increments rd_ptr.
- Pointers: wrap modulo DEPTH (natural PTR_W-bit rollover).
- Count update:
  - count+1 on push only;
  - count-1 on pop only;
  - unchanged on push and pop together (non-full, non-empty case).
- Flush (synchronous, highest priority below reset):
  - next cycle wr_ptr=rd_ptr=0 and count=0;
  - a push or pop offered in the flush cycle is discarded and has no effect;
  - storage contents are not cleared.
- No pop when empty: dec_ready while count=0 has no effect.
- No push when full: fetch_valid while full is ignored. Upstream holds the PC via pc_hold, so the same pair is re-offered.
- Reset mid-operation clears all state immediately, regardless of clk.
- No assertions on fetch_pc sequence; discontinuities (branch targets) are legal after a flush.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, fetch_valid=1 and flush=0, dec_valid=1 and dec_pc/dec_instr = fetch_pc/fetch_instr combinationally.
  - If dec_ready=1 in that cycle, the pair is consumed and not written; count stays 0 and the pointers are unchanged.
  - If dec_ready=0, the pair is pushed normally.
  - This gives 0-cycle latency when empty.
- Not defined: pure 1-cycle latency as above; no combinational fetch-to-decode path.

Test Plan:
- Reset: assert reset mid-cycle with count=3 -> immediately count=0, dec_valid=0, dec_pc=0, fetch_ready=1.
- Fill: push pc=0..3 with instr=0xA0..0xA3, dec_ready=0 -> count=4, fetch_ready=0, pc_hold=1. A 5th offer (pc=4) is ignored; the head stays pc=0/0xA0.
- Streaming: fetch_valid=1 and dec_ready=1 continuously for 20 cycles with pc 0..19 -> decode receives pc 0..19 in order, 1-cycle latency, count steady at 1. Pointers wrap past DEPTH without loss.
- Flush: queue holds pc=5,6,7; flush=1 with a simultaneous push pc=8 and pop -> next cycle count=0, dec_valid=0. A subsequent push of pc=0x20 appears as the head.
- Full plus pop: count=4, dec_ready=1, fetch_valid=1 -> pop only, count=3; the offered pair is accepted the next cycle.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, push pc=9/instr=0x13 with dec_ready=1 -> same-cycle dec_valid=1 and dec_pc=9, count remains 0. Same stimulus without the macro -> dec_valid rises one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between PC/instruction-memory and decode.
// Holds up to DEPTH (pc, instruction) pairs and presents them to decode in order
// through a valid/ready handshake. It holds the PC when full and discards all
// buffered work on a taken-branch redirect (flush).
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an offered pair
// straight to decode when the queue is empty (0-cycle latency). In the default
// build there is no combinational path from fetch to decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instr,
  output logic             fetch_ready,
  output logic             pc_hold,
  output logic             dec_valid,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_instr,
  input  logic             dec_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Storage is split into pc and instruction arrays sharing one pointer pair.
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count_nxt;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Full/empty depend on the occupancy only, so fetch_ready never waits on
  // dec_ready; a pop in a full cycle does not make room for a same-cycle push.
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign fetch_ready = ~full;
  assign pc_hold     = full;

  // A redirect cancels any handshake offered in the same cycle.
  assign push = fetch_valid & ~full & ~flush;
  assign pop  = ~empty & dec_ready & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards the offered pair directly; if decode takes it in
  // the same cycle it is never written and the queue stays empty.
  assign bypass    = empty & fetch_valid & ~flush;
  assign wr_en     = push & ~(bypass & dec_ready);
  assign dec_valid = ~empty | bypass;
  assign dec_pc    = bypass ? fetch_pc    : pc_mem[rd_ptr];
  assign dec_instr = bypass ? fetch_instr : instr_mem[rd_ptr];
`else
  // Head entry comes straight from storage; when empty it is stale and
  // dec_valid tells decode to ignore it.
  assign wr_en     = push;
  assign dec_valid = ~empty;
  assign dec_pc    = pc_mem[rd_ptr];
  assign dec_instr = instr_mem[rd_ptr];
`endif

  // Next pointer/occupancy: flush dominates, otherwise advance on each handshake.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Entry storage: cleared by reset, written on push, left intact by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (wr_en) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= fetch_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. The driver offers pairs like
// an upstream PC stage (re-offering while held, jumping to a target on flush)
// and pushes accepted pairs into an expected-order queue; a monitor on the
// falling edge compares decode outputs and status against that queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_instr;
  logic             fetch_ready;
  logic             pc_hold;
  logic             dec_valid;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_instr;
  logic             dec_ready;
  logic [PTR_W:0]   count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  pair_t       q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  bit          rand_instr = 1'b0;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  logic [31:0] flush_target;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .pc_hold     (pc_hold),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_ready   (dec_ready),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_instr(input logic [31:0] pc);
    if (rand_instr) return $urandom;
    return 32'hA0 + pc;
  endfunction

  // One upstream cycle: drive after the rising edge, then record the outcome
  // of the coming edge in the expected queue once the monitor has sampled.
  task automatic drive_cycle(input bit fv, input bit dr, input bit fl);
    bit full_now;
    bit empty_now;
    @(posedge clk);
    #1;
    full_now    = (q.size() == DEPTH);
    empty_now   = (q.size() == 0);
    fetch_valid = fv;
    fetch_pc    = cur_pc;
    fetch_instr = cur_instr;
    dec_ready   = dr;
    flush       = fl;
    @(negedge clk);
    #1;
    if (fl) begin
      q.delete();
      cur_pc    = flush_target;
      cur_instr = next_instr(cur_pc);
    end else if (fv && !full_now) begin
      if (!(BYPASS && empty_now && dr)) q.push_back({cur_pc, cur_instr});
      cur_pc    = cur_pc + 32'd1;
      cur_instr = next_instr(cur_pc);
    end
  endtask

  // Monitor: compare status and head against the expected queue, retire on pop.
  always @(negedge clk) begin
    bit    byp;
    bit    exp_valid;
    pair_t head;
    if (mon_en) begin
      byp       = BYPASS && (q.size() == 0) && fetch_valid && !flush;
      exp_valid = (q.size() != 0) || byp;
      head      = '0;
      if (byp) head = {fetch_pc, fetch_instr};
      else if (q.size() != 0) head = q[0];
      check("count", 32'(count), 32'(q.size()));
      check("fetch_ready", 32'(fetch_ready), 32'(q.size() != DEPTH));
      check("pc_hold", 32'(pc_hold), 32'(q.size() == DEPTH));
      check("dec_valid", 32'(dec_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("dec_pc", dec_pc, head.pc);
        check("dec_instr", dec_instr, head.instr);
      end
      if (!byp && (q.size() != 0) && dec_ready && !flush) void'(q.pop_front());
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    fetch_valid  = 1'b0;
    fetch_pc     = '0;
    fetch_instr  = '0;
    dec_ready    = 1'b0;
    cur_pc       = 32'd0;
    cur_instr    = next_instr(32'd0);
    flush_target = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_pc_hold", 32'(pc_hold), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Fill to full; extra offers of pc=4 are held off
    repeat (6) drive_cycle(1'b1, 1'b0, 1'b0);
    // Full plus pop: pop only, then pc=4 accepted next cycle
    drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0);

    // Streaming pc 0..19 with decode always ready
    cur_pc    = 32'd0;
    cur_instr = next_instr(cur_pc);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);

    // Flush with simultaneous push and pop, then redirect to 0x20
    cur_pc    = 32'd5;
    cur_instr = next_instr(cur_pc);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    flush_target = 32'h20;
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);

    // Empty queue, pc=9/instr=0x13 offered with decode ready
    cur_pc    = 32'd9;
    cur_instr = 32'h13;
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b1, 1'b0);

    // Randomized traffic: a backpressure-heavy half, then a drain-heavy half
    rand_instr = 1'b1;
    cur_instr  = next_instr(cur_pc);
    for (int i = 0; i < 600; i++) begin
      flush_target = $urandom;
      drive_cycle($urandom_range(0, 3) != 0,
                  (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset mid-cycle with three entries held
    drive_cycle(1'b0, 1'b0, 1'b1);
    rand_instr = 1'b0;
    cur_pc     = 32'h40;
    cur_instr  = next_instr(cur_pc);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    #2;
    check("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_dec_pc", dec_pc, 32'd0);
    check("mid_rst_fetch_ready", 32'(fetch_ready), 32'd1);
    q.delete();
    @(negedge clk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;
    cur_pc    = 32'h50;
    cur_instr = next_instr(cur_pc);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
